// File: rtl/dff_mem_pkg.sv
// Shared types and constants for the two-requester DFF RAM controller.
// The RAM control byte carries lr_n in bit 7, ce_n in bit 6 and the address in the low bits.
package dff_mem_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   localparam int           LR_N_BIT      = 7;
   localparam int           CE_N_BIT      = 6;
   localparam logic [7:0]   CTRL_IDLE     = 8'hC0;
   localparam int           MAX_RAM_BYTES = 64;

   // Writes drive lr_n low with ce_n high; reads drive ce_n low with lr_n high.
   function automatic logic [7:0] ctrl_cmd(input logic we, input logic [5:0] addr);
      logic [7:0] c;
      c           = {2'b00, addr};
      c[LR_N_BIT] = ~we;
      c[CE_N_BIT] = we;
      return c;
   endfunction

endpackage

// File: rtl/dff_mem_ctrl_if.sv
// Requester-side command/response bus for dff_mem_ctrl; requester 1 sits in the upper slices.
interface dff_mem_ctrl_if #(
   parameter int ADDR_BITS = 4
);
   logic [1:0]             req_valid;
   logic [1:0]             req_we;
   logic [2*ADDR_BITS-1:0] req_addr;
   logic [15:0]            req_wdata;
   logic [1:0]             req_ready;
   logic [1:0]             rsp_valid;
   logic [7:0]             rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_q;

   // On contention the requester that did not win last time gets the grant.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_q <= 1'b1;
      else if (accept)
         last_q <= grant[1];
   end

endmodule

// File: rtl/dff_mem_ctrl.sv
// Serialises read/write commands from two requesters onto the tt_um_dff_mem control and data
// buses, and returns registered read data on a per-requester one-cycle strobe.
module dff_mem_ctrl
   import dff_mem_pkg::*;
#(
   parameter int RAM_BYTES = 16
) (
   input  logic         clk,
   input  logic         rst,
   dff_mem_ctrl_if.slave bus,
   output logic [7:0]   mem_ui_in,
   output logic [7:0]   mem_uio_in,
   input  logic [7:0]   mem_uio_out,
   output logic         busy
);

   localparam int ADDR_BITS = $clog2(RAM_BYTES);

   if (RAM_BYTES > MAX_RAM_BYTES || RAM_BYTES < 2 || (RAM_BYTES & (RAM_BYTES - 1)) != 0) begin : g_bad_depth
      $error("dff_mem_ctrl: RAM_BYTES must be a power of two between 2 and 64");
   end

   state_t                 state;
   logic                   id_q;
   logic                   we_q;
   logic [1:0]             arb_req;
   logic [1:0]             grant;
   logic                   accept;
   logic                   gid;
   logic                   sel_we;
   logic [ADDR_BITS-1:0]   sel_addr;
   logic [7:0]             sel_wdata;

   assign arb_req = bus.req_valid & {2{state == IDLE}};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (arb_req),
      .accept (accept),
      .grant  (grant)
   );

   assign bus.req_ready = grant;
   assign accept        = |grant;
   assign busy          = (state != IDLE);

   assign gid       = grant[1];
   assign sel_we    = gid ? bus.req_we[1] : bus.req_we[0];
   assign sel_addr  = gid ? bus.req_addr[2*ADDR_BITS-1:ADDR_BITS] : bus.req_addr[ADDR_BITS-1:0];
   assign sel_wdata = gid ? bus.req_wdata[15:8] : bus.req_wdata[7:0];

   // The RAM samples the command at the end of ISSUE; a read's data is on uio_out during CAPTURE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         mem_ui_in     <= CTRL_IDLE;
         mem_uio_in    <= 8'h00;
         id_q          <= 1'b0;
         we_q          <= 1'b0;
         bus.rsp_valid <= 2'b00;
         bus.rsp_rdata <= 8'h00;
      end else begin
         bus.rsp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (accept) begin
                  mem_ui_in  <= ctrl_cmd(sel_we, 6'(sel_addr));
                  mem_uio_in <= sel_we ? sel_wdata : 8'h00;
                  id_q       <= gid;
                  we_q       <= sel_we;
                  state      <= ISSUE;
               end else begin
                  mem_ui_in  <= CTRL_IDLE;
               end
            end
            ISSUE: begin
               mem_ui_in <= CTRL_IDLE;
               state     <= we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
               bus.rsp_rdata <= mem_uio_out;
               bus.rsp_valid <= id_q ? 2'b10 : 2'b01;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Bench for dff_mem_ctrl: behavioural RAM stand-in, transaction-level reference model, directed and random traffic.
module tb_dff_mem_ctrl;
   import dff_mem_pkg::*;

   localparam int RAM_BYTES = 16;
   localparam int ADDR_BITS = $clog2(RAM_BYTES);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] mem_ui_in, mem_uio_in, mem_uio_out;
   logic       busy;

   dff_mem_ctrl_if #(.ADDR_BITS(ADDR_BITS)) bus ();

   dff_mem_ctrl #(.RAM_BYTES(RAM_BYTES)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mem_ui_in   (mem_ui_in),
      .mem_uio_in  (mem_uio_in),
      .mem_uio_out (mem_uio_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // RAM stand-in: lr_n low loads uio_in, ce_n low registers the addressed byte onto uio_out.
   logic [7:0] ram [RAM_BYTES];
   always @(posedge clk) begin
      if (!mem_ui_in[7]) ram[mem_ui_in[ADDR_BITS-1:0]] <= mem_uio_in;
      if (!mem_ui_in[6]) mem_uio_out <= ram[mem_ui_in[ADDR_BITS-1:0]];
   end

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: transaction timing in cycle numbers plus a plain memory array.
   int         cyc;
   int         m_free_at;
   int         m_ui_cyc;
   int         m_rsp_cyc;
   int         m_last_gnt;
   logic [7:0] m_ui_val, m_uio_val, m_rsp_data, m_rdata;
   logic       m_rsp_id;
   logic [7:0] ref_mem [RAM_BYTES];

   // Pending command per requester, held until the model predicts acceptance.
   logic [1:0] pv, pwe;
   logic [3:0] pa [2];
   logic [7:0] pd [2];

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_free_at  = cyc;
      m_ui_cyc   = -1;
      m_rsp_cyc  = -1;
      m_last_gnt = 1;
      m_rdata    = 8'h00;
   endtask

   task automatic reset_checks();
      chk("rst_mem_ui_in",  mem_ui_in,           8'hC0);
      chk("rst_mem_uio_in", mem_uio_in,          8'h00);
      chk("rst_rsp_valid",  8'(bus.rsp_valid),   8'h00);
      chk("rst_rsp_rdata",  bus.rsp_rdata,       8'h00);
      chk("rst_busy",       8'(busy),            8'h00);
      chk("rst_req_ready",  8'(bus.req_ready),   8'h00);
   endtask

   // One clock cycle: drive at the falling edge, check this cycle's outputs, advance the model.
   task automatic step(input bit rnd);
      logic [1:0] exp_ready, exp_rspv;
      logic [7:0] exp_ui;
      bit         idle;
      int         w;
      if (rnd) begin
         for (int r = 0; r < 2; r++) begin
            if (!pv[r] && $urandom_range(0, 2) == 0) begin
               pv[r]  = 1'b1;
               pwe[r] = 1'($urandom_range(0, 1));
               pa[r]  = 4'($urandom);
               pd[r]  = 8'($urandom);
            end else if (pv[r] && $urandom_range(0, 15) == 0) begin
               pv[r] = 1'b0;
            end
         end
      end
      bus.req_valid = pv;
      bus.req_we    = pwe;
      bus.req_addr  = {pa[1], pa[0]};
      bus.req_wdata = {pd[1], pd[0]};
      #1;
      idle      = (cyc >= m_free_at);
      exp_ready = 2'b00;
      if (idle) begin
         if (pv == 2'b11) exp_ready = (m_last_gnt == 0) ? 2'b10 : 2'b01;
         else             exp_ready = pv;
      end
      exp_ui   = (cyc == m_ui_cyc) ? m_ui_val : 8'hC0;
      exp_rspv = 2'b00;
      if (cyc == m_rsp_cyc) begin
         exp_rspv = m_rsp_id ? 2'b10 : 2'b01;
         m_rdata  = m_rsp_data;
      end
      chk("req_ready", 8'(bus.req_ready), 8'(exp_ready));
      chk("busy",      8'(busy),          8'(!idle));
      chk("mem_ui_in", mem_ui_in,         exp_ui);
      if (cyc == m_ui_cyc) chk("mem_uio_in", mem_uio_in, m_uio_val);
      chk("rsp_valid", 8'(bus.rsp_valid), 8'(exp_rspv));
      chk("rsp_rdata", bus.rsp_rdata,     m_rdata);
      if (exp_ready != 2'b00) begin
         w          = exp_ready[1] ? 1 : 0;
         m_last_gnt = w;
         m_ui_cyc   = cyc + 1;
         m_ui_val   = (pwe[w] ? 8'h40 : 8'h80) + 8'(pa[w]);
         m_uio_val  = pwe[w] ? pd[w] : 8'h00;
         if (pwe[w]) begin
            ref_mem[pa[w]] = pd[w];
            m_free_at      = cyc + 2;
         end else begin
            m_rsp_cyc  = cyc + 3;
            m_rsp_id   = 1'(w);
            m_rsp_data = ref_mem[pa[w]];
            m_free_at  = cyc + 3;
         end
         pv[w] = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((pv != 2'b00 || cyc < m_free_at || cyc <= m_rsp_cyc) && n < max) begin
         step(1'b0);
         n++;
      end
      chk("drain_in_time", 8'(n < max), 8'd1);
   endtask

   task automatic post(input int r, input logic we, input logic [3:0] a, input logic [7:0] d);
      pv[r]  = 1'b1;
      pwe[r] = we;
      pa[r]  = a;
      pd[r]  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < RAM_BYTES; i++) begin
         ram[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      mem_uio_out = 8'h00;
      pv = 2'b00; pwe = 2'b00;
      pa[0] = 4'h0; pa[1] = 4'h0; pd[0] = 8'h00; pd[1] = 8'h00;
      bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
      cyc = 0;

      @(negedge clk);
      reset_checks();
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Write A5 to address 3 from requester 0, then read it back.
      post(0, 1'b1, 4'd3, 8'hA5);
      drain(20);
      post(0, 1'b0, 4'd3, 8'h00);
      drain(20);

      // Continuous contention between two readers.
      post(0, 1'b1, 4'd1, 8'h11);
      post(1, 1'b1, 4'd2, 8'h22);
      drain(20);
      repeat (24) begin
         if (!pv[0]) post(0, 1'b0, 4'd1, 8'h00);
         if (!pv[1]) post(1, 1'b0, 4'd2, 8'h00);
         step(1'b0);
      end
      drain(20);

      // Requester 1 writes, requester 0 reads the same address next.
      post(1, 1'b1, 4'd15, 8'h5A);
      drain(20);
      post(0, 1'b0, 4'd15, 8'h00);
      drain(20);

      // Requester 1 pulses valid for one cycle while the controller is busy.
      post(0, 1'b0, 4'd5, 8'h00);
      step(1'b0);
      post(1, 1'b1, 4'd7, 8'hEE);
      step(1'b0);
      pv[1] = 1'b0;
      drain(20);
      post(0, 1'b0, 4'd7, 8'h00);
      drain(20);

      // Back-to-back writes over every address, then back-to-back reads.
      for (int i = 0; i < RAM_BYTES; i++) begin
         post(0, 1'b1, 4'(i), 8'(i * 7 + 3));
         n = 0;
         while (pv[0] && n < 10) begin step(1'b0); n++; end
      end
      for (int i = 0; i < RAM_BYTES; i++) begin
         post(0, 1'b0, 4'(i), 8'h00);
         n = 0;
         while (pv[0] && n < 10) begin step(1'b0); n++; end
      end
      drain(20);

      // Random traffic with occasional withdrawn requests.
      repeat (3000) step(1'b1);
      pv = 2'b00;
      drain(20);

      // Reset while a read is in CAPTURE: outputs clear at once and the response is dropped.
      post(0, 1'b0, 4'd3, 8'h00);
      step(1'b0);
      step(1'b0);
      rst = 1'b1;
      bus.req_valid = 2'b00;
      #1;
      reset_checks();
      @(negedge clk);
      reset_checks();
      rst = 1'b0;
      cyc++;
      model_reset();
      repeat (4) step(1'b0);

      // RAM contents survive the controller reset.
      post(0, 1'b0, 4'd3, 8'h00);
      drain(20);
      post(1, 1'b0, 4'd15, 8'h00);
      drain(20);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
